dla_reset_release_sequencer: RTL and testbench

//   Consumer end of the DLA platform reset. Takes the distributed, unsynchronized platform reset.

---
 rtl/dla_reset_release_sequencer_if.sv | 24 ++
 rtl/dla_reset_release_sequencer.sv | 164 ++++++++++++++++
 tb/tb_dla_reset_release_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dla_reset_release_sequencer_if.sv
// Stage handshake bundle for dla_reset_release_sequencer: per-stage resets out, per-stage ready in,
// plus the completion and sticky timeout flags.
interface dla_reset_release_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic [NUM_STAGES-1:0] i_stage_ready;
    logic [NUM_STAGES-1:0] o_stage_reset;
    logic                  o_all_released;
    logic                  o_timeout;

    modport master (
        input  i_stage_ready,
        output o_stage_reset,
        output o_all_released,
        output o_timeout
    );

    modport slave (
        output i_stage_ready,
        input  o_stage_reset,
        input  o_all_released,
        input  o_timeout
    );
endinterface

// File: rtl/dla_reset_release_sequencer.sv
// Ordered reset release for DLA sub-blocks: synchronizes platform reset release, then frees stages one by one.
// Optional synchronous soft reset port enabled by defining DLA_RESET_SEQ_SOFT_RESET_EN.
module dla_reset_release_sequencer #(
    parameter int NUM_STAGES           = 4,
    parameter int SYNC_STAGES          = 3,
    parameter int STAGE_DELAY_CYCLES   = 16,
    parameter int READY_TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic i_async_reset,
`ifdef DLA_RESET_SEQ_SOFT_RESET_EN
    input  logic i_soft_reset,
`endif
    dla_reset_release_sequencer_if.master seq_if
);

    localparam int DLY_W   = $clog2(STAGE_DELAY_CYCLES + 1);
    localparam int TO_W    = (READY_TIMEOUT_CYCLES > 0) ? $clog2(READY_TIMEOUT_CYCLES + 1) : 1;
    localparam int IDX_W   = $clog2(NUM_STAGES) + 1;
    localparam int TO_LAST = (READY_TIMEOUT_CYCLES > 0) ? READY_TIMEOUT_CYCLES - 1 : 0;

    generate
        if (STAGE_DELAY_CYCLES < 1) begin : g_bad_delay
            $error("STAGE_DELAY_CYCLES must be >= 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be >= 2");
        end
        if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_stages
            $error("NUM_STAGES must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_DELAY,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic [TO_W-1:0]         to_q, to_d;
    logic [NUM_STAGES-1:0]   stage_reset_q, stage_reset_d;
    logic                    all_q, all_d;
    logic                    timeout_q, timeout_d;
    logic                    ready_cur;
    logic                    timed_out;
    logic                    sync_rel;

    // Chain is thermometer-coded; release is the edge on which the last flop captures 0.
    assign sync_rel  = (sync_q[SYNC_STAGES-1 -: 2] != 2'b11);
    assign timed_out = (READY_TIMEOUT_CYCLES > 0) && (to_q == TO_W'(TO_LAST));

    always_ff @(posedge clk or posedge i_async_reset) begin
        if (i_async_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge i_async_reset) begin
        if (i_async_reset) begin
            state_q       <= ST_SYNC;
            idx_q         <= '0;
            dly_q         <= '0;
            to_q          <= '0;
            stage_reset_q <= '1;
            all_q         <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dly_q         <= dly_d;
            to_q          <= to_d;
            stage_reset_q <= stage_reset_d;
            all_q         <= all_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dly_d         = dly_q;
        to_d          = to_q;
        stage_reset_d = stage_reset_q;
        all_d         = all_q;
        timeout_d     = timeout_q;
        ready_cur     = 1'b0;

        for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                ready_cur = seq_if.i_stage_ready[k];
            end
        end

        case (state_q)
            ST_SYNC: begin
                if (sync_rel) begin
                    state_d = ST_DELAY;
                    dly_d   = '0;
                end
            end
            ST_DELAY: begin
                if (dly_q == DLY_W'(STAGE_DELAY_CYCLES - 1)) begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            stage_reset_d[k] = 1'b0;
                        end
                    end
                    state_d = ST_WAIT;
                    to_d    = '0;
                end else if (dly_q < DLY_W'(STAGE_DELAY_CYCLES)) begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (ready_cur || timed_out) begin
                    if (!ready_cur) begin
                        timeout_d = 1'b1;
                    end
                    if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                        all_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        dly_d   = '0;
                        state_d = ST_DELAY;
                    end
                end else if (to_q < TO_W'(TO_LAST)) begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

`ifdef DLA_RESET_SEQ_SOFT_RESET_EN
        // Soft reset skips the synchronizer: the chain has already settled low.
        if (i_soft_reset) begin
            state_d       = ST_DELAY;
            idx_d         = '0;
            dly_d         = '0;
            to_d          = '0;
            stage_reset_d = '1;
            all_d         = 1'b0;
            timeout_d     = 1'b0;
        end
`endif
    end

    assign seq_if.o_stage_reset  = stage_reset_q;
    assign seq_if.o_all_released = all_q;
    assign seq_if.o_timeout      = timeout_q;

endmodule

// File: tb/tb_dla_reset_release_sequencer.sv
// Directed bench for dla_reset_release_sequencer: nominal release table plus stall, timeout,
// mid-sequence reset, early-ready and (with DLA_RESET_SEQ_SOFT_RESET_EN) soft reset sequences.
module tb_dla_reset_release_sequencer;

    typedef struct {
        int         edge_n;
        logic [3:0] exp_rst;
        logic       exp_all;
        logic       exp_to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    vec_t       t1 [10];

    always #5 clk = ~clk;

    dla_reset_release_sequencer_if #(.NUM_STAGES(4)) if_a ();
    dla_reset_release_sequencer_if #(.NUM_STAGES(4)) if_b ();

`ifdef DLA_RESET_SEQ_SOFT_RESET_EN
    logic soft = 1'b0;
`endif

    dla_reset_release_sequencer #(
        .NUM_STAGES(4), .SYNC_STAGES(3), .STAGE_DELAY_CYCLES(4), .READY_TIMEOUT_CYCLES(1024)
    ) dut_a (
        .clk(clk),
        .i_async_reset(rst),
`ifdef DLA_RESET_SEQ_SOFT_RESET_EN
        .i_soft_reset(soft),
`endif
        .seq_if(if_a)
    );

    dla_reset_release_sequencer #(
        .NUM_STAGES(4), .SYNC_STAGES(3), .STAGE_DELAY_CYCLES(4), .READY_TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk),
        .i_async_reset(rst),
`ifdef DLA_RESET_SEQ_SOFT_RESET_EN
        .i_soft_reset(soft),
`endif
        .seq_if(if_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cnt < n) begin
            @(posedge clk);
            cnt++;
        end
        #1;
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 10; i++) begin
            goto(t1[i].edge_n);
            chk($sformatf("%s e%0d stage", tag, t1[i].edge_n), 32'(if_a.o_stage_reset), 32'(t1[i].exp_rst));
            chk($sformatf("%s e%0d all", tag, t1[i].edge_n), 32'(if_a.o_all_released), 32'(t1[i].exp_all));
            chk($sformatf("%s e%0d tmo", tag, t1[i].edge_n), 32'(if_a.o_timeout), 32'(t1[i].exp_to));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t1[0] = '{6,  4'b1111, 1'b0, 1'b0};
        t1[1] = '{7,  4'b1110, 1'b0, 1'b0};
        t1[2] = '{11, 4'b1110, 1'b0, 1'b0};
        t1[3] = '{12, 4'b1100, 1'b0, 1'b0};
        t1[4] = '{16, 4'b1100, 1'b0, 1'b0};
        t1[5] = '{17, 4'b1000, 1'b0, 1'b0};
        t1[6] = '{21, 4'b1000, 1'b0, 1'b0};
        t1[7] = '{22, 4'b0000, 1'b0, 1'b0};
        t1[8] = '{23, 4'b0000, 1'b1, 1'b0};
        t1[9] = '{30, 4'b0000, 1'b1, 1'b0};

        if_a.i_stage_ready = 4'b1111;
        if_b.i_stage_ready = 4'b1111;

        // reset state
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset stage", 32'(if_a.o_stage_reset), 32'hF);
        chk("reset all", 32'(if_a.o_all_released), 32'h0);
        chk("reset tmo", 32'(if_b.o_timeout), 32'h0);

        // nominal release
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        run_table("t1");

        // async reset pulse after stages 0,1 released
        restart();
        goto(14);
        chk("t4 pre stage", 32'(if_a.o_stage_reset), 32'hC);
        #1 rst = 1'b1;
        #1;
        chk("t4 async stage", 32'(if_a.o_stage_reset), 32'hF);
        chk("t4 async all", 32'(if_a.o_all_released), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        run_table("t4");

        // stage 1 ready held low for 50 edges
        if_a.i_stage_ready = 4'b1101;
        restart();
        goto(12);
        chk("t2 e12 stage", 32'(if_a.o_stage_reset), 32'hC);
        goto(62);
        chk("t2 e62 stage", 32'(if_a.o_stage_reset), 32'hC);
        if_a.i_stage_ready = 4'b1111;
        goto(66);
        chk("t2 e66 stage", 32'(if_a.o_stage_reset), 32'hC);
        goto(67);
        chk("t2 e67 stage", 32'(if_a.o_stage_reset), 32'h8);
        chk("t2 e67 tmo", 32'(if_a.o_timeout), 32'h0);
        goto(72);
        chk("t2 e72 stage", 32'(if_a.o_stage_reset), 32'h0);
        goto(73);
        chk("t2 e73 all", 32'(if_a.o_all_released), 32'h1);
        chk("t2 e73 tmo", 32'(if_a.o_timeout), 32'h0);

        // ready timeout on stage 0 (dut_b, timeout 16)
        if_b.i_stage_ready = 4'b1110;
        restart();
        goto(7);
        chk("t3 e7 stage", 32'(if_b.o_stage_reset), 32'hE);
        goto(22);
        chk("t3 e22 tmo", 32'(if_b.o_timeout), 32'h0);
        goto(23);
        chk("t3 e23 tmo", 32'(if_b.o_timeout), 32'h1);
        chk("t3 e23 stage", 32'(if_b.o_stage_reset), 32'hE);
        goto(26);
        chk("t3 e26 stage", 32'(if_b.o_stage_reset), 32'hE);
        goto(27);
        chk("t3 e27 stage", 32'(if_b.o_stage_reset), 32'hC);
        goto(38);
        chk("t3 e38 stage", 32'(if_b.o_stage_reset), 32'h0);
        chk("t3 e38 all", 32'(if_b.o_all_released), 32'h1);
        chk("t3 e38 tmo", 32'(if_b.o_timeout), 32'h1);

        // early ready on unreleased stages is ignored
        if_a.i_stage_ready = 4'b1110;
        restart();
        goto(7);
        chk("t5 e7 stage", 32'(if_a.o_stage_reset), 32'hE);
        goto(12);
        chk("t5 e12 stage", 32'(if_a.o_stage_reset), 32'hE);
        if_a.i_stage_ready = 4'b0001;
        goto(16);
        chk("t5 e16 stage", 32'(if_a.o_stage_reset), 32'hE);
        goto(17);
        chk("t5 e17 stage", 32'(if_a.o_stage_reset), 32'hC);
        if_a.i_stage_ready = 4'b1111;
        goto(21);
        chk("t5 e21 stage", 32'(if_a.o_stage_reset), 32'hC);
        goto(22);
        chk("t5 e22 stage", 32'(if_a.o_stage_reset), 32'h8);
        goto(27);
        chk("t5 e27 stage", 32'(if_a.o_stage_reset), 32'h0);
        chk("t5 e27 all", 32'(if_a.o_all_released), 32'h0);
        goto(28);
        chk("t5 e28 all", 32'(if_a.o_all_released), 32'h1);
        chk("t5 e28 tmo", 32'(if_a.o_timeout), 32'h0);

`ifdef DLA_RESET_SEQ_SOFT_RESET_EN
        // soft reset from DONE
        goto(30);
        soft = 1'b1;
        goto(31);
        chk("t6 e31 stage", 32'(if_a.o_stage_reset), 32'hF);
        chk("t6 e31 all", 32'(if_a.o_all_released), 32'h0);
        chk("t6 e31 tmo b", 32'(if_b.o_timeout), 32'h0);
        soft = 1'b0;
        goto(34);
        chk("t6 e34 stage", 32'(if_a.o_stage_reset), 32'hF);
        goto(35);
        chk("t6 e35 stage", 32'(if_a.o_stage_reset), 32'hE);
        goto(40);
        chk("t6 e40 stage", 32'(if_a.o_stage_reset), 32'hC);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
